motion_bbox_extract: RTL and testbench
======================================

# motion_bbox_extract

Frame-level bounding-box extractor for the frame-difference motion path. Consumes the cleaned binary motion mask from the dilation stage, tracks min/max column and row of all foreground pixels plus a foreground pixel count across one frame, and publishes one registered box record per frame at frame end. Feeds the overlay stage and any software/status readout that needs the box as numbers rather than pixels.

## Interface
- IMG_HDISP, 10'd640, active pixels per line
- IMG_VDISP, 10'd480, active lines per frame
- MIN_PIXELS, 19'd64, minimum foreground count for a frame to report motion
- clk  in  1  pixel-domain clock
- rst_n  in  1  reset; synchronous, active-low
- dilation_vsync  in  1  frame valid, high for whole frame
- dilation_href  in  1  line valid
- dilation_clken  in  1  pixel strobe
- dilation_img_Bit  in  1  mask bit, 1 = motion
- box_valid  out  1  one-cycle pulse, new record on outputs
- box_hit  out  1  frame count >= MIN_PIXELS
- box_x_min, box_x_max  out  10 each  column bounds, inclusive
- box_y_min, box_y_max  out  10 each  row bounds, inclusive
- box_pix_cnt  out  19  foreground pixel count of the frame
- box_ovf  out  1  sticky-per-frame: pixels beyond IMG_HDISP or lines beyond IMG_VDISP seen

## Operation
- Qualified pixel: dilation_vsync & dilation_href & dilation_clken.
- x counter: 0 at href low; +1 per qualified pixel. y counter: 0 at frame start; +1 on href falling edge (inside frame).
- Pixel with x >= IMG_HDISP or line with y >= IMG_VDISP: not accumulated, sets frame ovf flag.
- Foreground pixel (qualified, bit=1, in range): x_min=min, x_max=max, y_min=min, y_max=max, cnt+1 saturating at 19'h7FFFF.
- Accumulators init at frame start: x_min=IMG_HDISP-1, y_min=IMG_VDISP-1, x_max=y_max=0, cnt=0, ovf=0.
- FSM: IDLE -> ACCUM on vsync rising edge (partial frame after reset discarded); ACCUM -> LATCH on vsync falling edge; LATCH -> ACCUM if vsync rising edge sampled in LATCH (accumulators re-init), else -> WAIT; WAIT -> ACCUM on rising edge.
- LATCH: box_hit = (cnt >= MIN_PIXELS); if hit, coordinates = accumulators, else all four coordinates = 0; box_pix_cnt = cnt, box_ovf = ovf, box_valid = 1.
- Outputs hold between pulses.

## Timing
- Reset: all outputs 0; FSM IDLE; accumulators at init values.
- Edges from one-cycle-delayed vsync/href samples.
- Accumulator update registered on the clk edge sampling the pixel; no input stall.
- First clk edge sampling vsync low after high = edge E. FSM in LATCH after E; box_valid and record registered on edge E+1, valid high exactly one cycle.
- Reset asserted mid-frame: next edge forces IDLE, no box_valid; reporting resumes after one full vsync high period.
- Pixel sampled on same edge as vsync falling edge is not qualified (vsync low).
- Frame of zero qualified pixels: box_valid still pulses, box_hit=0, cnt=0.

## Structure
- Shared package imgd_pkg: IMG_HDISP/IMG_VDISP defaults, COORD_W=10, CNT_W=19, bbox_t struct (x_min, x_max, y_min, y_max, pix_cnt, hit, ovf), FSM enum bbox_state_e {IDLE, ACCUM, LATCH, WAIT}.
- One sub-module: sync_edge_detect (registered rise/fall pulses), instantiated for vsync and href.

## Test plan
- Reset then 640x480 frame, foreground pixels only at (100,50) and (200,300), MIN_PIXELS=2 -> one box_valid, hit=1, x 100..200, y 50..300, cnt=2, ovf=0.
- Same frame with MIN_PIXELS=64 -> hit=0, coordinates 0, cnt=2.
- Reset released mid-frame with foreground present -> no pulse at that frame's end; next full frame reports correctly.
- All-ones frame -> x 0..639, y 0..479, cnt=307200; following all-zero frame -> hit=0, cnt=0 (no stale accumulation).
- Line with 650 pixel strobes, foreground at x=645 -> pixel ignored, ovf=1, box excludes it.
- Vsync rises on the cycle after falling (LATCH cycle) -> box_valid once for frame 1, frame 2 accumulated from clean init.

Source files
------------

// File: rtl/imgd_pkg.sv
// Shared image-path types: frame geometry defaults, box record layout and
// the frame-tracking FSM encoding.
package imgd_pkg;
    localparam int COORD_W = 10;
    localparam int CNT_W   = 19;

    localparam logic [COORD_W-1:0] IMG_HDISP_DEF = 10'd640;
    localparam logic [COORD_W-1:0] IMG_VDISP_DEF = 10'd480;
    localparam logic [CNT_W-1:0]   CNT_MAX       = '1;

    typedef struct packed {
        logic [COORD_W-1:0] x_min;
        logic [COORD_W-1:0] x_max;
        logic [COORD_W-1:0] y_min;
        logic [COORD_W-1:0] y_max;
        logic [CNT_W-1:0]   pix_cnt;
        logic               hit;
        logic               ovf;
    } bbox_t;

    typedef enum logic [1:0] {IDLE, ACCUM, LATCH, WAIT} bbox_state_e;

    // Empty-frame accumulator: mins start at the far corner so the first
    // foreground pixel overwrites them.
    function automatic bbox_t bbox_init(input logic [COORD_W-1:0] hdisp,
                                        input logic [COORD_W-1:0] vdisp);
        bbox_t b;
        b       = '0;
        b.x_min = hdisp - 1'b1;
        b.y_min = vdisp - 1'b1;
        return b;
    endfunction
endpackage

// File: rtl/sync_edge_detect.sv
// Rise/fall detection of a level against its previous clock sample.
module sync_edge_detect (
    input  logic clk,
    input  logic d,
    output logic rise,
    output logic fall
);
    logic d_q;

    // Tracks the input even through reset, so a level already high at reset
    // release is never mistaken for a fresh rising edge.
    always_ff @(posedge clk) d_q <= d;

    assign rise = d & ~d_q;
    assign fall = ~d & d_q;
endmodule

// File: rtl/motion_bbox_extract.sv
// Per-frame bounding box, foreground count and overflow flag of the binary
// motion mask, published as one registered record at each frame end.
module motion_bbox_extract
    import imgd_pkg::*;
#(
    parameter logic [COORD_W-1:0] IMG_HDISP  = IMG_HDISP_DEF,
    parameter logic [COORD_W-1:0] IMG_VDISP  = IMG_VDISP_DEF,
    parameter logic [CNT_W-1:0]   MIN_PIXELS = 19'd64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               dilation_vsync,
    input  logic               dilation_href,
    input  logic               dilation_clken,
    input  logic               dilation_img_Bit,
    output logic               box_valid,
    output logic               box_hit,
    output logic [COORD_W-1:0] box_x_min,
    output logic [COORD_W-1:0] box_x_max,
    output logic [COORD_W-1:0] box_y_min,
    output logic [COORD_W-1:0] box_y_max,
    output logic [CNT_W-1:0]   box_pix_cnt,
    output logic               box_ovf
);
    logic vs_rise, vs_fall, href_rise_unused, href_fall;
    logic pix, in_range, hit;
    logic [COORD_W-1:0] x_cnt, y_cnt;
    bbox_state_e state, state_nxt;
    bbox_t acc, rec;

    sync_edge_detect u_vs_edge (
        .clk (clk), .d (dilation_vsync), .rise (vs_rise), .fall (vs_fall)
    );
    sync_edge_detect u_href_edge (
        .clk (clk), .d (dilation_href), .rise (href_rise_unused), .fall (href_fall)
    );

    assign pix      = dilation_vsync & dilation_href & dilation_clken;
    assign in_range = (x_cnt < IMG_HDISP) && (y_cnt < IMG_VDISP);
    assign hit      = (acc.pix_cnt >= MIN_PIXELS);

    // Counters saturate so an absurdly long line or frame stays out of range.
    always_ff @(posedge clk) begin
        if (!rst_n || !dilation_href)
            x_cnt <= '0;
        else if (pix && x_cnt != '1)
            x_cnt <= x_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || vs_rise)
            y_cnt <= '0;
        else if (dilation_vsync && href_fall && y_cnt != '1)
            y_cnt <= y_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (vs_rise) state_nxt = ACCUM;
            ACCUM:   if (vs_fall) state_nxt = LATCH;
            LATCH:   state_nxt = vs_rise ? ACCUM : WAIT;
            WAIT:    if (vs_rise) state_nxt = ACCUM;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || vs_rise) begin
            acc <= bbox_init(IMG_HDISP, IMG_VDISP);
        end else if (state == ACCUM && pix) begin
            if (!in_range) begin
                acc.ovf <= 1'b1;
            end else if (dilation_img_Bit) begin
                if (x_cnt < acc.x_min) acc.x_min <= x_cnt;
                if (x_cnt > acc.x_max) acc.x_max <= x_cnt;
                if (y_cnt < acc.y_min) acc.y_min <= y_cnt;
                if (y_cnt > acc.y_max) acc.y_max <= y_cnt;
                if (acc.pix_cnt != CNT_MAX) acc.pix_cnt <= acc.pix_cnt + 1'b1;
            end
        end
    end

    // A frame below threshold reports a zero box so overlay draws nothing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            box_valid <= 1'b0;
            rec       <= '0;
        end else begin
            box_valid <= (state == LATCH);
            if (state == LATCH) begin
                rec.hit     <= hit;
                rec.x_min   <= hit ? acc.x_min : '0;
                rec.x_max   <= hit ? acc.x_max : '0;
                rec.y_min   <= hit ? acc.y_min : '0;
                rec.y_max   <= hit ? acc.y_max : '0;
                rec.pix_cnt <= acc.pix_cnt;
                rec.ovf     <= acc.ovf;
            end
        end
    end

    assign box_hit     = rec.hit;
    assign box_x_min   = rec.x_min;
    assign box_x_max   = rec.x_max;
    assign box_y_min   = rec.y_min;
    assign box_y_max   = rec.y_max;
    assign box_pix_cnt = rec.pix_cnt;
    assign box_ovf     = rec.ovf;
endmodule

// File: tb/tb_motion_bbox_extract.sv
// Randomized frames against a frame-level box model, plus directed frames
// with hand-computed records.
module tb_motion_bbox_extract;
    localparam logic [9:0]  H    = 10'd16;
    localparam logic [9:0]  V    = 10'd12;
    localparam logic [18:0] MINP = 19'd4;

    logic clk = 1'b0, rst_n = 1'b0;
    logic vs = 1'b0, hr = 1'b0, ce = 1'b0, bt = 1'b0;
    logic box_valid, box_hit, box_ovf;
    logic [9:0] xmin, xmax, ymin, ymax;
    logic [18:0] pcnt;

    motion_bbox_extract #(.IMG_HDISP(H), .IMG_VDISP(V), .MIN_PIXELS(MINP)) dut (
        .clk(clk), .rst_n(rst_n),
        .dilation_vsync(vs), .dilation_href(hr), .dilation_clken(ce), .dilation_img_Bit(bt),
        .box_valid(box_valid), .box_hit(box_hit),
        .box_x_min(xmin), .box_x_max(xmax), .box_y_min(ymin), .box_y_max(ymax),
        .box_pix_cnt(pcnt), .box_ovf(box_ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    bit rst_smp = 1'b0;
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rst_smp <= !rst_n;
    end

    typedef struct {
        int xmin, xmax, ymin, ymax, cnt;
        bit hit, ovf;
        int at;
    } rec_t;

    rec_t exp_q[$];
    int nvec = 0, nerr = 0;
    bit pat[32][32];

    function automatic void chk(string nm, longint act, longint ex);
        nvec++;
        if (act !== ex) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, ex, cyc);
        end
    endfunction

    // Frame record from the picture itself: every strobed pixel outside the
    // active window flags overflow, foreground inside it grows the box.
    function automatic rec_t model(int nl, int np);
        rec_t r;
        r.xmin = int'(H) - 1; r.ymin = int'(V) - 1;
        r.xmax = 0; r.ymax = 0; r.cnt = 0; r.ovf = 0; r.at = 0;
        for (int y = 0; y < nl; y++)
            for (int x = 0; x < np; x++)
                if (x >= int'(H) || y >= int'(V)) r.ovf = 1;
                else if (pat[y][x]) begin
                    if (x < r.xmin) r.xmin = x;
                    if (x > r.xmax) r.xmax = x;
                    if (y < r.ymin) r.ymin = y;
                    if (y > r.ymax) r.ymax = y;
                    r.cnt++;
                end
        r.hit = (r.cnt >= int'(MINP));
        if (!r.hit) begin r.xmin = 0; r.xmax = 0; r.ymin = 0; r.ymax = 0; end
        return r;
    endfunction

    logic [60:0] outs, last = '0;
    assign outs = {box_hit, box_ovf, xmin, xmax, ymin, ymax, pcnt};

    always @(negedge clk) begin
        rec_t e;
        if (rst_smp) begin
            chk("reset_outputs", {box_valid, outs}, 0);
            last = '0;
        end else if (box_valid) begin
            if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("valid_cycle", cyc, e.at);
                chk("hit", box_hit, e.hit);
                chk("x_min", xmin, e.xmin);
                chk("x_max", xmax, e.xmax);
                chk("y_min", ymin, e.ymin);
                chk("y_max", ymax, e.ymax);
                chk("pix_cnt", pcnt, e.cnt);
                chk("ovf", box_ovf, e.ovf);
            end
            last = outs;
        end else begin
            chk("hold", outs, last);
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic drive_frame(int nl, int np, int gap_pct, bit tail,
                               int rst_line, bit report, bit b2b);
        rec_t e;
        e = model(nl, np);
        vs = 1; hr = 0; ce = 0;
        step(); step();
        for (int y = 0; y < nl; y++) begin
            if (y == rst_line) begin
                rst_n = 0; repeat (3) step(); rst_n = 1;
            end
            hr = 1;
            for (int x = 0; x < np; x++) begin
                while ($urandom_range(99) < gap_pct) begin
                    ce = 0; bt = 1'($urandom); step();
                end
                ce = 1; bt = pat[y][x]; step();
            end
            hr = 0;
            repeat ($urandom_range(1, 3)) begin
                ce = 1'($urandom); bt = 1'($urandom); step();
            end
        end
        // Optional strobe coinciding with vsync low must not count.
        if (tail) begin hr = 1; ce = 1; bt = 1; end
        else      begin hr = 0; ce = 0; end
        vs = 0;
        e.at = cyc + 2;
        if (report) exp_q.push_back(e);
        step();
        hr = 0; ce = 0; bt = 0;
        if (!b2b) repeat ($urandom_range(2, 5)) step();
    endtask

    task automatic clear_pat();
        for (int y = 0; y < 32; y++)
            for (int x = 0; x < 32; x++) pat[y][x] = 0;
    endtask

    task automatic fill_pat(int pct);
        for (int y = 0; y < 32; y++)
            for (int x = 0; x < 32; x++) pat[y][x] = ($urandom_range(99) < pct);
    endtask

    task automatic lit(int h, int x0, int x1, int y0, int y1, int c, int o);
        chk("lit_hit", box_hit, h);
        chk("lit_x_min", xmin, x0);
        chk("lit_x_max", xmax, x1);
        chk("lit_y_min", ymin, y0);
        chk("lit_y_max", ymax, y1);
        chk("lit_pix_cnt", pcnt, c);
        chk("lit_ovf", box_ovf, o);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (4) step();
        rst_n = 1;
        step();

        clear_pat();
        pat[2][3] = 1; pat[9][10] = 1;
        drive_frame(12, 16, 20, 0, -1, 1, 0);
        lit(0, 0, 0, 0, 0, 2, 0);

        pat[5][5] = 1; pat[1][7] = 1;
        drive_frame(12, 16, 20, 1, -1, 1, 0);
        lit(1, 3, 10, 1, 9, 4, 0);

        fill_pat(100);
        drive_frame(12, 16, 10, 0, -1, 1, 0);
        lit(1, 0, 15, 0, 11, 192, 0);

        clear_pat();
        drive_frame(12, 16, 10, 0, -1, 1, 0);
        lit(0, 0, 0, 0, 0, 0, 0);

        pat[2][18] = 1; pat[4][6] = 1; pat[6][8] = 1; pat[3][2] = 1; pat[7][9] = 1;
        drive_frame(12, 20, 10, 0, -1, 1, 0);
        lit(1, 2, 9, 3, 7, 4, 1);

        // Mid-frame reset: that frame is dropped, the next one reports.
        fill_pat(100);
        drive_frame(12, 16, 10, 0, 5, 0, 0);
        clear_pat();
        pat[2][3] = 1; pat[9][10] = 1; pat[5][5] = 1; pat[1][7] = 1;
        drive_frame(12, 16, 10, 0, -1, 1, 0);
        lit(1, 3, 10, 1, 9, 4, 0);

        // Back-to-back frames: second starts in the latch cycle.
        fill_pat(100);
        drive_frame(12, 16, 0, 0, -1, 1, 1);
        clear_pat();
        pat[11][15] = 1; pat[0][0] = 1; pat[6][4] = 1; pat[3][12] = 1; pat[8][1] = 1;
        drive_frame(12, 16, 0, 0, -1, 1, 0);
        lit(1, 0, 15, 0, 11, 5, 0);

        for (int f = 0; f < 40; f++) begin
            int dens, rl;
            bit rep;
            case ($urandom_range(2))
                0:       dens = 2;
                1:       dens = 5;
                default: dens = 50;
            endcase
            fill_pat(dens);
            rl  = ($urandom_range(7) == 0) ? int'($urandom_range(0, 9)) : -1;
            rep = (rl < 0);
            drive_frame(int'($urandom_range(V - 2, V + 1)), int'($urandom_range(H - 3, H + 2)),
                        int'($urandom_range(0, 40)), 1'($urandom), rl, rep, 1'($urandom));
        end

        repeat (10) step();
        chk("pending_records", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
